// File: rtl/request_encoder_7to3.sv
// Collects per-source request pulses into a pending vector and offers them one
// at a time as 1-based indices over a valid/ready handshake (round-robin or fixed priority).
module request_encoder_7to3 #(
    parameter int ROUND_ROBIN = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] req_in,
    output logic [2:0] idx_out,
    output logic       idx_valid,
    input  logic       idx_ready,
    output logic [6:0] pending,
    output logic       busy,
    output logic       dup_req
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    state_t     state_r;
    state_t     state_s;
    logic [6:0] pending_r;
    logic [6:0] pending_s;
    logic [6:0] clr_s;
    logic [6:0] remain_s;
    logic [2:0] idx_r;
    logic [2:0] idx_s;
    logic [2:0] last_grant_r;
    logic [2:0] last_grant_s;
    logic [2:0] grant_bit_s;
    logic       accept_s;
    logic       busy_r;
    logic       dup_req_r;

    // Bit positions run 0..6 and wrap from 6 back to 0.
    function automatic logic [2:0] next_pos(input logic [2:0] pos);
        next_pos = (pos >= 3'd6) ? 3'd0 : pos + 3'd1;
    endfunction

    function automatic logic [2:0] pick_first(input logic [6:0] vec, input logic [2:0] start);
        logic [2:0] pos;
        logic       found;
        pick_first = 3'd0;
        found      = 1'b0;
        pos        = start;
        for (int i = 0; i < 7; i++) begin
            if (!found && vec[pos]) begin
                pick_first = pos;
                found      = 1'b1;
            end
            pos = next_pos(pos);
        end
    endfunction

    // Fixed priority always searches from bit 0; round-robin starts just past the last grant.
    function automatic logic [2:0] search_start(input logic [2:0] last);
        search_start = (ROUND_ROBIN != 0) ? next_pos(last) : 3'd0;
    endfunction

    // Accept decode and pending update; a new request beats the clear on the same bit.
    always_comb begin
        accept_s    = (state_r == OFFER) && idx_ready;
        grant_bit_s = idx_r - 3'd1;
        if (accept_s) begin
            clr_s = 7'd1 << grant_bit_s;
        end else begin
            clr_s = 7'd0;
        end
        remain_s  = pending_r & ~clr_s;
        pending_s = remain_s | req_in;
    end

    // Next-state and next-index logic; requests arriving this cycle never feed the selection.
    always_comb begin
        state_s      = state_r;
        idx_s        = idx_r;
        last_grant_s = last_grant_r;
        case (state_r)
            IDLE: begin
                if (|pending_r) begin
                    state_s = OFFER;
                    idx_s   = pick_first(pending_r, search_start(last_grant_r)) + 3'd1;
                end else begin
                    idx_s = 3'd0;
                end
            end
            OFFER: begin
                if (accept_s) begin
                    last_grant_s = grant_bit_s;
                    if (|remain_s) begin
                        idx_s = pick_first(remain_s, search_start(grant_bit_s)) + 3'd1;
                    end else begin
                        state_s = IDLE;
                        idx_s   = 3'd0;
                    end
                end else begin
                    idx_s = idx_r;
                end
            end
            default: begin
                state_s = IDLE;
                idx_s   = 3'd0;
            end
        endcase
    end

    // State, index, pending and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            idx_r        <= 3'd0;
            pending_r    <= 7'd0;
            last_grant_r <= 3'd6;
            busy_r       <= 1'b0;
            dup_req_r    <= 1'b0;
        end else begin
            state_r      <= state_s;
            idx_r        <= idx_s;
            pending_r    <= pending_s;
            last_grant_r <= last_grant_s;
            busy_r       <= (|pending_s) | (state_s == OFFER);
            dup_req_r    <= |(req_in & pending_r);
        end
    end

    assign idx_out   = idx_r;
    assign idx_valid = (state_r == OFFER);
    assign pending   = pending_r;
    assign busy      = busy_r;
    assign dup_req   = dup_req_r;

endmodule
